// File: rtl/upsampling_pkg.sv
// Shared constants and types for the upsampling front end: window geometry,
// the row/column-to-tap mapping and the window generator's state type.
package upsampling_pkg;

  localparam int YCBCR_WIDTH_DEF = 12;
  localparam int WIN_DIM         = 4;
  localparam int TAPS            = WIN_DIM * WIN_DIM;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } win_state_t;

  // Tap index of window element (row r, column c); row 0 is the oldest line.
  function automatic int win_idx(input int r, input int c);
    return r * WIN_DIM + c;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One line of pixel storage: simple dual-port RAM with a registered read port.
// Contents are never reset.
module line_ram #(
  parameter  int DEPTH = 3840,
  parameter  int WIDTH = 12,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/window_gen_4x4.sv
// Raster stream to 4x4 neighbourhood generator: three prior lines in RAM,
// a two-stage pipeline, one packed 16-tap window per qualifying pixel.
module window_gen_4x4
  import upsampling_pkg::*;
#(
  parameter int YCbCr_WIDTH = YCBCR_WIDTH_DEF,
  parameter int LINE_WIDTH  = 3840
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [YCbCr_WIDTH-1:0]      i_pixel_data,
  input  logic                        i_data_valid,
  input  logic                        i_sof,
  output logic [TAPS*YCbCr_WIDTH-1:0] o_pixel_data,
  output logic                        o_data_valid,
  output win_state_t                  state
);

  // Stream semantics: i_data_valid=1 means the pixel is taken this cycle (no
  // ready); o_data_valid is a one-cycle pulse per window, o_pixel_data holds otherwise.
  localparam int             CW       = $clog2(LINE_WIDTH);
  localparam logic [CW-1:0]  LAST_COL = CW'(LINE_WIDTH - 1);
  localparam logic [CW-1:0]  MIN_COL  = CW'(WIN_DIM - 1);

  logic [CW-1:0] col_q, col_eff;
  logic [1:0]    line_q, line_eff, wb_q, wb_eff;
  logic          accept_sof, wrap, run, emit;
  win_state_t    state_q, state_d;

  assign accept_sof = i_data_valid & i_sof;

  always_comb begin
    col_eff  = accept_sof ? '0 : col_q;
    line_eff = accept_sof ? '0 : line_q;
    wb_eff   = accept_sof ? '0 : wb_q;
    wrap     = (col_eff == LAST_COL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      line_q <= '0;
      wb_q   <= '0;
    end else if (i_data_valid) begin
      col_q  <= wrap ? '0 : col_eff + 1'b1;
      line_q <= (wrap && line_eff != 2'd3) ? line_eff + 2'd1 : line_eff;
      wb_q   <= wrap ? wb_eff + 2'd1 : wb_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept_sof)
      state_d = ST_FILL;
    else if (i_data_valid && wrap && line_eff == 2'd2)
      state_d = ST_RUN;
  end

  always_comb begin
    run  = (state_q == ST_RUN) && !accept_sof;
    emit = i_data_valid && run && (col_eff >= MIN_COL);
  end

  assign state = state_q;

  logic [YCbCr_WIDTH-1:0] rd_data [4];

  for (genvar b = 0; b < 4; b++) begin : g_bank
    line_ram #(
      .DEPTH (LINE_WIDTH),
      .WIDTH (YCbCr_WIDTH)
    ) u_line_ram (
      .clk   (clk),
      .we    (i_data_valid && (wb_eff == 2'(b))),
      .waddr (col_eff),
      .wdata (i_pixel_data),
      .re    (i_data_valid),
      .raddr (col_eff),
      .rdata (rd_data[b])
    );
  end

  // Stage 1: the RAM read registers sit alongside these.
  logic                   s1_valid, s1_emit;
  logic [YCbCr_WIDTH-1:0] s1_pix;
  logic [1:0]             s1_wb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_emit  <= 1'b0;
      s1_pix   <= '0;
      s1_wb    <= '0;
    end else begin
      s1_valid <= i_data_valid;
      if (i_data_valid) begin
        s1_emit <= emit;
        s1_pix  <= i_pixel_data;
        s1_wb   <= wb_eff;
      end
    end
  end

  // A new frame kills the pixel still in stage 1 so no old window survives.
  logic                         s1_live;
  logic [YCbCr_WIDTH-1:0]       col_vec [WIN_DIM];
  logic [YCbCr_WIDTH-1:0]       win_q   [WIN_DIM][WIN_DIM];
  logic [YCbCr_WIDTH-1:0]       win_nxt [WIN_DIM][WIN_DIM];
  logic [TAPS*YCbCr_WIDTH-1:0]  win_flat;

  assign s1_live = s1_valid && !accept_sof;

  always_comb begin
    for (int k = 0; k < WIN_DIM - 1; k++)
      col_vec[k] = rd_data[s1_wb + 2'(k + 1)];
    col_vec[WIN_DIM-1] = s1_pix;
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < WIN_DIM; r++) begin
      for (int c = 0; c < WIN_DIM - 1; c++)
        win_nxt[r][c] = win_q[r][c+1];
      win_nxt[r][WIN_DIM-1] = col_vec[r];
    end
    for (int r = 0; r < WIN_DIM; r++)
      for (int c = 0; c < WIN_DIM; c++)
        win_flat[win_idx(r, c)*YCbCr_WIDTH +: YCbCr_WIDTH] = win_nxt[r][c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < WIN_DIM; r++)
        for (int c = 0; c < WIN_DIM; c++)
          win_q[r][c] <= '0;
      o_data_valid <= 1'b0;
      o_pixel_data <= '0;
    end else begin
      if (s1_live) win_q <= win_nxt;
      o_data_valid <= s1_live && s1_emit;
      if (s1_live && s1_emit) o_pixel_data <= win_flat;
    end
  end

endmodule

// File: tb/tb_window_gen_4x4.sv
// Bench for window_gen_4x4 with 8-pixel lines: directed frames checked against a
// tap table, plus random streams checked against a frame-history window model.
module tb_window_gen_4x4;
  import upsampling_pkg::*;

  localparam int YW = 12;
  localparam int LW = 8;
  localparam int OW = 16 * YW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [YW-1:0] i_pixel_data = '0;
  logic          i_data_valid = 1'b0;
  logic          i_sof = 1'b0;
  logic [OW-1:0] o_pixel_data;
  logic          o_data_valid;
  win_state_t    st;

  always #5 clk = ~clk;

  window_gen_4x4 #(.YCbCr_WIDTH(YW), .LINE_WIDTH(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pixel_data (i_pixel_data),
    .i_data_valid (i_data_valid),
    .i_sof        (i_sof),
    .o_pixel_data (o_pixel_data),
    .o_data_valid (o_data_valid),
    .state        (st)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected windows and the cycle each must appear in.
  logic [OW-1:0] exp_q[$];
  int            due_q[$];
  logic [OW-1:0] cap_q[$];
  logic [OW-1:0] t2_q[$];
  logic [OW-1:0] last_win = '0;
  logic          mon_en = 1'b0;

  // Reference model: frame position and the last four lines of pixels.
  logic [YW-1:0] hist [4][LW];
  int            m_line = 0;
  int            m_col  = 0;

  typedef struct {
    int            grp;
    int            win;
    int            elem;
    logic [YW-1:0] exp;
  } dir_t;
  dir_t tbl [11];

  function automatic void check(input string name, input logic [OW-1:0] act,
                                input logic [OW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        check("window_valid", OW'(o_data_valid), OW'(1));
        check("window_data", o_pixel_data, exp_q[0]);
        last_win = exp_q[0];
        cap_q.push_back(o_pixel_data);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end else begin
        check("no_valid", OW'(o_data_valid), OW'(0));
        check("hold_data", o_pixel_data, last_win);
        if (due_q.size() > 0 && due_q[0] < cyc) begin
          n_vec++;
          n_err++;
          $display("FAIL missed_window: due cyc %0d, now %0d", due_q[0], cyc);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
    end
  end

  task automatic px(input logic [YW-1:0] d, input logic sof);
    logic [OW-1:0] w;
    if (sof) begin
      m_line = 0;
      m_col  = 0;
      while (due_q.size() > 0 && due_q[$] == cyc + 1) begin
        void'(exp_q.pop_back());
        void'(due_q.pop_back());
      end
    end
    hist[m_line % 4][m_col] = d;
    if (m_line >= 3 && m_col >= 3) begin
      w = '0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          w[(r*4+c)*YW +: YW] = hist[(m_line - 3 + r) % 4][m_col - 3 + c];
      exp_q.push_back(w);
      due_q.push_back(cyc + 2);
    end
    m_col++;
    if (m_col == LW) begin
      m_col = 0;
      m_line++;
    end
    i_pixel_data = d;
    i_sof        = sof;
    i_data_valid = 1'b1;
    @(posedge clk); #1;
    i_data_valid = 1'b0;
    i_sof        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // mode 0: base + line*16 + col, 1: all 0xFFF, 2: random values.
  task automatic send_frame(input int npix, input logic [YW-1:0] base, input int mode,
                            input int mingap, input int maxgap);
    logic [YW-1:0] v;
    for (int i = 0; i < npix; i++) begin
      case (mode)
        0:       v = base + YW'((i / LW) * 16 + (i % LW));
        1:       v = 12'hFFF;
        default: v = YW'($urandom);
      endcase
      px(v, i == 0);
      if (maxgap > 0) idle($urandom_range(maxgap, mingap));
    end
  endtask

  task automatic check_tbl(input int grp);
    logic [OW-1:0] w;
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].grp == grp) begin
        if (tbl[i].win < cap_q.size()) begin
          w = cap_q[tbl[i].win];
          check($sformatf("tap_g%0d_w%0d_e%0d", grp, tbl[i].win, tbl[i].elem),
                OW'(w[tbl[i].elem*YW +: YW]), OW'(tbl[i].exp));
        end else begin
          check($sformatf("tap_g%0d_w%0d_present", grp, tbl[i].win),
                OW'(cap_q.size()), OW'(tbl[i].win + 1));
        end
      end
    end
  endtask

  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_valid_async", OW'(o_data_valid), OW'(0));
    check("reset_data_async", o_pixel_data, '0);
    exp_q.delete();
    due_q.delete();
    last_win = '0;
    m_line   = 0;
    m_col    = 0;
    idle(2);
    check("reset_state", OW'(st), OW'(ST_FILL));
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    tbl[0]  = '{2, 0, 0,  12'h000};
    tbl[1]  = '{2, 0, 10, 12'h022};
    tbl[2]  = '{2, 0, 15, 12'h033};
    tbl[3]  = '{2, 0, 5,  12'h011};
    tbl[4]  = '{2, 0, 3,  12'h003};
    tbl[5]  = '{2, 4, 15, 12'h037};
    tbl[6]  = '{2, 4, 0,  12'h004};
    tbl[7]  = '{2, 4, 10, 12'h026};
    tbl[8]  = '{4, 0, 0,  12'h800};
    tbl[9]  = '{4, 0, 15, 12'h833};
    tbl[10] = '{4, 4, 15, 12'h837};

    idle(2);
    check("init_valid", OW'(o_data_valid), OW'(0));
    check("init_data", o_pixel_data, '0);
    rst_n = 1'b1;
    idle(1);
    mon_en = 1'b1;

    // Four continuous lines.
    cap_q.delete();
    send_frame(4 * LW, 12'h000, 0, 0, 0);
    idle(4);
    check("t2_count", OW'(cap_q.size()), OW'(5));
    check("t2_state_run", OW'(st), OW'(ST_RUN));
    check_tbl(2);
    t2_q = cap_q;

    // Same stream with 1-3 cycle gaps.
    cap_q.delete();
    send_frame(4 * LW, 12'h000, 0, 1, 3);
    idle(4);
    check("t3_count", OW'(cap_q.size()), OW'(t2_q.size()));
    for (int i = 0; i < cap_q.size() && i < t2_q.size(); i++)
      check($sformatf("t3_same_w%0d", i), cap_q[i], t2_q[i]);

    // Random values, random gaps, longer frame.
    send_frame(7 * LW, 12'h000, 2, 0, 2);
    idle(4);

    // New frame arriving at line 2, column 4.
    send_frame(2 * LW + 4, 12'h100, 0, 0, 0);
    check("t4_state_fill", OW'(st), OW'(ST_FILL));
    cap_q.delete();
    send_frame(4 * LW, 12'h800, 0, 0, 0);
    idle(4);
    check("t4_count", OW'(cap_q.size()), OW'(5));
    check_tbl(4);

    // Reset while line 3 is streaming, then a fresh frame.
    send_frame(3 * LW + 6, 12'h200, 0, 0, 0);
    pulse_reset();
    send_frame(4 * LW, 12'h400, 0, 0, 0);
    idle(4);

    // Saturated pixel values.
    cap_q.delete();
    send_frame(4 * LW, 12'h000, 1, 0, 0);
    idle(4);
    check("t6_count", OW'(cap_q.size()), OW'(5));
    for (int i = 0; i < cap_q.size(); i++)
      check($sformatf("t6_all_ones_w%0d", i), cap_q[i], {16{12'hFFF}});

    check("pending_windows", OW'(exp_q.size()), OW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
